// File: rtl/sort_drain.sv
// sort_drain
//   Captures a snapshot of sorter cell max values on a load strobe and drains
//   them one beat at a time over a valid/ready output. It then pulses
//   done/chain_clr for one cycle so the sorter chain can clear its registers.
//
//   Optional build macro: SORT_DRAIN_SKIP_ZERO_EN
//     When defined, cells holding zero (empty) are skipped. A snapshot with
//     every cell empty goes straight to DONE without emitting any beat.
//
//   Parameters
//     DW     data word width
//     DEPTH  number of sorter cells per snapshot (>= 2)
//
//   Ports
//     clk        clock, rising edge
//     rst_n      asynchronous active-low reset
//     load       snapshot strobe (ignored while busy)
//     snap       cell values, cell i at [i*DW +: DW], cell 0 largest
//     out_data   current beat value (0 when not valid)
//     out_valid  beat valid
//     out_ready  downstream accepts beat
//     out_last   current beat is the final one of the snapshot
//     busy       snapshot held and not yet fully drained
//     done       one-cycle pulse after the final beat is accepted
//     chain_clr  one-cycle pulse with done, clears the sorter chain
//
//   state | meaning
//   IDLE  | waiting for load, buffer contents stale
//   SEND  | presenting buffer[index] as a beat
//   DONE  | single cycle: done/chain_clr pulse, then back to IDLE
module sort_drain #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [DW*DEPTH-1:0] snap,
  output logic [DW-1:0]       out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                busy,
  output logic                done,
  output logic                chain_clr
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [DW-1:0]   cell_q [DEPTH];
  logic            load_en;
  logic [IW-1:0]   nxt_idx;
  logic            has_next;

`ifdef SORT_DRAIN_SKIP_ZERO_EN
  logic [IW-1:0]   first_idx;
  logic            any_nz;

  // Downward scans so the lowest qualifying cell wins.
  always_comb begin
    first_idx = '0;
    any_nz    = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (snap[i*DW +: DW] != '0) begin
        first_idx = IW'(i);
        any_nz    = 1'b1;
      end
    end
    nxt_idx  = idx_q;
    has_next = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if ((i > int'(idx_q)) && (cell_q[i] != '0)) begin
        nxt_idx  = IW'(i);
        has_next = 1'b1;
      end
    end
  end
`else
  always_comb begin
    has_next = (idx_q != IW'(DEPTH - 1));
    nxt_idx  = has_next ? idx_q + 1'b1 : idx_q;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      for (int i = 0; i < DEPTH; i++) cell_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (load_en) begin
        for (int i = 0; i < DEPTH; i++) cell_q[i] <= snap[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          load_en = 1'b1;
`ifdef SORT_DRAIN_SKIP_ZERO_EN
          idx_d   = first_idx;
          state_d = any_nz ? SEND : DONE;
`else
          idx_d   = '0;
          state_d = SEND;
`endif
        end
      end
      SEND: begin
        if (out_ready) begin
          if (!has_next) state_d = DONE;
          else           idx_d   = nxt_idx;
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Outputs decode straight from registered state so reset clears them at once.
  always_comb begin
    out_valid = (state_q == SEND);
    out_data  = out_valid ? cell_q[idx_q] : '0;
    out_last  = out_valid && !has_next;
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    chain_clr = (state_q == DONE);
  end

endmodule

// File: tb/tb_sort_drain.sv
module tb_sort_drain;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic                clk;
  logic                rst_n;
  logic                load;
  logic [DW*DEPTH-1:0] snap;
  logic [DW-1:0]       out_data;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;
  logic                busy;
  logic                done;
  logic                chain_clr;

  sort_drain #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .snap(snap),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done), .chain_clr(chain_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] exp_q [$];   // {last, data}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted beat, checks stall stability.
  logic       stall;
  logic [7:0] pd;
  logic       pl;
  initial stall = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_data",  {24'd0, out_data}, {24'd0, pd});
        check("stall_last",  {31'd0, out_last}, {31'd0, pl});
      end
      if (out_valid) begin
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", {23'd0, out_last, out_data}, 32'h1ff);
          end else begin
            logic [8:0] e;
            e = exp_q.pop_front();
            check("beat", {23'd0, out_last, out_data}, {23'd0, e});
          end
          stall = 1'b0;
        end else begin
          stall = 1'b1;
        end
        pd = out_data;
        pl = out_last;
      end else begin
        stall = 1'b0;
        check("idle_outputs", {23'd0, out_last, out_data}, 32'd0);
      end
    end
  end

  function automatic logic [31:0] pack4(input logic [7:0] c0, c1, c2, c3);
    return {c3, c2, c1, c0};
  endfunction

  task automatic push(input logic [7:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  // Loads s, drives ready from rp (bit per cycle, then 1), waits for done.
  task automatic drain(input string name, input logic [31:0] s, input logic [15:0] rp,
                       input int exp_cyc, input logic ld_during);
    int  cyc;
    logic got;
    snap = s; load = 1'b1; out_ready = rp[0];
    @(posedge clk); #1;
    load = 1'b0;
    cyc = 0; got = 1'b0;
    while (cyc < 60 && !got) begin
      cyc++;
      @(negedge clk);
      if (done) got = 1'b1;
      else begin
        @(posedge clk); #1;
        out_ready = (cyc < 16) ? rp[cyc] : 1'b1;
        if (ld_during) begin
          load = (cyc < 3);
          snap = (cyc < 3) ? 32'hFFFF_FFFF : s;
        end
      end
    end
    check({name, "_done_seen"}, {31'd0, got}, 32'd1);
    if (exp_cyc >= 0) check({name, "_done_cycle"}, cyc, exp_cyc);
    check({name, "_chain_clr"}, {31'd0, chain_clr}, 32'd1);
    check({name, "_done_busy"}, {30'd0, busy, out_valid}, 32'd2);
    @(negedge clk);
    check({name, "_after"}, {30'd0, busy, done}, 32'd0);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    load = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic push_default;
    push(8'h90, 1'b0); push(8'h40, 1'b0); push(8'h20, 1'b0); push(8'h05, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; snap = '0; out_ready = 1'b1;
    #1;
    check("reset_outputs", {21'd0, out_data, out_valid, out_last, busy, done, chain_clr}, 32'd0);
    #20;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back drain with ready high
    push_default();
    drain("basic", pack4(8'h90, 8'h40, 8'h20, 8'h05), 16'hFFFF, 5, 1'b0);

    // Stall three cycles while 0x40 is presented
    push_default();
    drain("stall", pack4(8'h90, 8'h40, 8'h20, 8'h05), 16'b1111_1111_1111_0001, 8, 1'b0);

    // Load attempts during SEND are ignored
    push_default();
    drain("ld_busy", pack4(8'h90, 8'h40, 8'h20, 8'h05), 16'hFFFF, 5, 1'b1);

    // Alternating ready, stall on the final beat too
    push(8'h11, 1'b0); push(8'h22, 1'b0); push(8'h7F, 1'b0); push(8'hC3, 1'b1);
    drain("alt", pack4(8'h11, 8'h22, 8'h7F, 8'hC3), 16'b1010_1010_1010_1010, 9, 1'b0);

    // Reset after the first beat is accepted
    snap = pack4(8'h90, 8'h40, 8'h20, 8'h05); load = 1'b1; out_ready = 1'b1;
    push(8'h90, 1'b0);
    @(posedge clk); #1; load = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_data", {24'd0, out_data}, 32'h40);
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", {21'd0, out_data, out_valid, out_last, busy, done, chain_clr}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("no_done_after_reset", {30'd0, done, chain_clr}, 32'd0);
    @(posedge clk); #1;
    push_default();
    drain("post_reset", pack4(8'h90, 8'h40, 8'h20, 8'h05), 16'hFFFF, 5, 1'b0);

`ifdef SORT_DRAIN_SKIP_ZERO_EN
    push(8'h33, 1'b1);
    drain("one_nz", pack4(8'h33, 8'h00, 8'h00, 8'h00), 16'hFFFF, 2, 1'b0);
    drain("all_zero", 32'd0, 16'hFFFF, 1, 1'b0);
    push(8'h40, 1'b0); push(8'h05, 1'b1);
    drain("gaps", pack4(8'h00, 8'h40, 8'h00, 8'h05), 16'hFFFF, 3, 1'b0);
`else
    push(8'h33, 1'b0); push(8'h00, 1'b0); push(8'h00, 1'b0); push(8'h00, 1'b1);
    drain("one_nz", pack4(8'h33, 8'h00, 8'h00, 8'h00), 16'hFFFF, 5, 1'b0);
    push(8'h00, 1'b0); push(8'h00, 1'b0); push(8'h00, 1'b0); push(8'h00, 1'b1);
    drain("all_zero", 32'd0, 16'hFFFF, 5, 1'b0);
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sort_drain.md
SORT_DRAIN -- requirements
Module: sort_drain

Interface
REQ-001 SHALL have parameter DW, default 8, the data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, the number of sorter cells drained per load (DEPTH >= 2).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port load  input  1  snapshot strobe, sampled at a rising edge.
REQ-006 SHALL have port snap  input  DW*DEPTH  cell max values; cell i at bits [i*DW +: DW]; cell 0 holds the largest value.
REQ-007 SHALL have port out_data  output  DW  current beat value.
REQ-008 SHALL have port out_valid  output  1  out_data is valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the beat.
REQ-010 SHALL have port out_last  output  1  current beat is the final beat of the snapshot.
REQ-011 SHALL have port busy  output  1  a snapshot is held and not yet fully drained.
REQ-012 SHALL have port done  output  1  one-cycle pulse after the final beat is accepted.
REQ-013 SHALL have port chain_clr  output  1  one-cycle pulse, coincident with done, requesting the sorter chain to clear its max registers.

Function
REQ-014 SHALL implement FSM states IDLE, SEND, DONE.
REQ-015 In IDLE, load=1 SHALL capture snap into an internal buffer, set index to the first emitted entry, and move to SEND.
REQ-016 The first beat SHALL appear (out_valid=1) in the cycle immediately after the load edge; busy=1 in SEND and DONE.
REQ-017 In SEND, out_valid SHALL be 1 and out_data SHALL equal buffer[index].
REQ-018 A beat is transferred only on a rising edge with out_valid=1 and out_ready=1.
REQ-019 While out_valid=1 and out_ready=0, out_data and out_last SHALL be held stable.
REQ-020 On transfer of a non-final beat, index SHALL advance to the next emitted entry; with out_ready held high, beats SHALL be emitted on consecutive cycles.
REQ-021 out_last SHALL be 1 exactly when index is at the final emitted entry.
REQ-022 On transfer of the final beat, the FSM SHALL move to DONE.
REQ-023 DONE SHALL last exactly one cycle with done=1, chain_clr=1, out_valid=0, then return to IDLE.
REQ-024 load SHALL be ignored whenever busy=1; the buffer SHALL not change during SEND or DONE.
REQ-025 Outside SEND, out_valid and out_last SHALL be 0 and out_data SHALL be 0.
REQ-026 Index counter SHALL be ceil(log2(DEPTH)) bits minimum and SHALL never exceed DEPTH-1.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, index 0, buffer all-zero, and out_data, out_valid, out_last, busy, done, chain_clr to 0.
REQ-028 Reset mid-transfer SHALL abort the snapshot with no done or chain_clr pulse; the next load starts cleanly.

Configuration
REQ-029 Macro SORT_DRAIN_SKIP_ZERO_EN, when defined, SHALL emit only buffer entries not equal to zero (empty cells), in cell order, with out_last on the last non-zero entry.
REQ-030 With SORT_DRAIN_SKIP_ZERO_EN defined and all entries zero, load SHALL go directly to DONE (done pulse in the cycle after load, no out_valid).
REQ-031 Without SORT_DRAIN_SKIP_ZERO_EN, all DEPTH entries SHALL be emitted, including zeros.

Verification (DW=8, DEPTH=4; snap cells 0..3 = 0x90,0x40,0x20,0x05 unless stated)
REQ-032 Load, out_ready=1 -> beats 0x90,0x40,0x20,0x05 on four consecutive cycles, out_last only with 0x05, done+chain_clr next cycle, busy=0 after.
REQ-033 out_ready=0 for 3 cycles while 0x40 presented -> 0x40 held stable, no skip or duplicate, sequence otherwise unchanged.
REQ-034 load=1 with snap=0xFF,0xFF,0xFF,0xFF during SEND -> ignored; original sequence completes.
REQ-035 rst_n low after first beat accepted -> all outputs 0 immediately, no done; subsequent load drains full sequence from 0x90.
REQ-036 snap=0x33,0x00,0x00,0x00 -> without macro 4 beats 0x33,0x00,0x00,0x00; with SORT_DRAIN_SKIP_ZERO_EN one beat 0x33 with out_last=1.
REQ-037 snap all zero with SORT_DRAIN_SKIP_ZERO_EN -> out_valid never 1, done=1 in the cycle after load.
